window_3x3_builder: RTL and testbench
=====================================

# window_3x3_builder

Streaming neighbourhood generator for the image filter path. Accepts a raster-order RGB444 pixel stream, buffers two image lines, and emits one 108-bit 3x3 window per image pixel, packed exactly as the 3x3 filter modules consume it on `color_data`. Out-of-image neighbours are zero-filled, and the final row is flushed internally. The block sits between the frame-memory reader and any 3x3 filter module.

## Interface
- `IMG_W`, default 160: image width in pixels (≥3).
- `IMG_H`, default 120: image height in lines (≥2).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `pixel_in` input 12: RGB444 pixel, R[11:8] G[7:4] B[3:0].
- `pixel_valid` input 1: `pixel_in` is valid this cycle.
- `sof` input 1: qualifies with `pixel_valid`; marks raster index 0 of a frame.
- `in_ready` output 1: block accepts a pixel this cycle; acceptance = `pixel_valid & in_ready`.
- `color_data` output 108: window. [107:96] centre, [95:84] left, [83:72] right, [71:60] up, [59:48] down, [47:36] up-left, [35:24] up-right, [23:12] down-left, [11:0] down-right.
- `window_valid` output 1: `color_data` is valid this cycle; one-cycle strobe per window.
- `center_x` output clog2(IMG_W): column of the window centre.
- `center_y` output clog2(IMG_H): row of the window centre.
- `frame_done` output 1: one-cycle pulse coincident with the last window of a frame.

## Operation
- Storage:
  - Two line buffers, IMG_W x 12 each.
  - A 3x3 register window.
  - Input counters `in_x`/`in_y` and centre counters `cx`/`cy`.
- States:
  - IDLE: `in_ready`=1. A pixel accepted without `sof` is dropped. An accepted pixel with `sof` is stored as index 0, then go to STREAM.
  - STREAM: `in_ready`=1. Each accepted pixel advances the raster index n. For n ≥ IMG_W+1, the window for centre index n−(IMG_W+1) is emitted. Acceptance of index IMG_W·IMG_H−1 moves the block to FLUSH.
  - FLUSH: `in_ready`=0. Internally injects a zero pixel every cycle for IMG_W+1 cycles, emitting one window per cycle. Then return to IDLE.
- Window count: exactly IMG_W·IMG_H windows per frame, in raster order of the centre.
- Zero fill: a neighbour is forced to 12'h000 in any of these cases, regardless of buffer contents:
  - left when cx=0
  - right when cx=IMG_W−1
  - up when cy=0
  - down when cy=IMG_H−1
  - any corner whose row or column is outside the image
- Row wrap: pixels from the previous line never appear as left/right neighbours.
- `sof` accepted in STREAM: the current frame is aborted with no flush and no `frame_done`. The pixel becomes index 0 of the new frame.
- `sof` is ignored in FLUSH, since `in_ready`=0.
- `pixel_valid`=0 in STREAM: everything holds; no window is emitted.
- Pixel values pass through unmodified; there is no arithmetic on colour data.

## Timing
- Latency: the window is registered. `window_valid` rises in the cycle after the acceptance that completes the window, or after the FLUSH cycle that completes it.
- `color_data`, `center_x` and `center_y` hold their last values when `window_valid`=0.
- `frame_done` is asserted in the same cycle as the `window_valid` of centre (IMG_W−1, IMG_H−1).
- Reset, applied in any state including mid-frame or mid-flush, takes effect on the next clock edge:
  - state = IDLE, all counters = 0
  - `color_data` = 0, `window_valid` = 0, `frame_done` = 0
  - `center_x` = 0, `center_y` = 0, `in_ready` = 1 from the first cycle after reset
- Line-buffer contents are not cleared by reset. Masking guarantees that stale data never reaches an output.
- Throughput: one pixel per cycle sustained. Frame period = IMG_W·IMG_H + IMG_W + 1 cycles plus the IDLE gap.

## Test plan
- **Basic frame** (IMG_W=4, IMG_H=3): pixel value = index+1 (001..00C), `sof` on the first pixel, continuous valid.
  - First window appears the cycle after accepting index 5: centre 001, right 002, down 005, down-right 006, all others 000, (0,0).
  - Centre (1,1): centre 006, up 002, down 00A, left 005, right 007, up-left 001, up-right 003, down-left 009, down-right 00B.
- **Flush**: same frame.
  - `in_ready`=0 for exactly 5 cycles after the last acceptance.
  - Last window at (3,2): centre 00C, left 00B, up 008, up-left 007, others 000.
  - `frame_done` high in the same cycle; exactly 12 `window_valid` strobes in total.
- **Stalls**: same frame with `pixel_valid` randomly low 50% of cycles.
  - Identical window sequence; no `window_valid` in stall cycles.
- **Pre-sof and abort**:
  - 3 pixels without `sof` in IDLE produce no windows.
  - A `sof` at index 7 restarts the frame: no `frame_done`, and the next windows start at (0,0) with the new data.
- **Reset mid-frame**: reset asserted after index 8.
  - Next cycle: all outputs 0, `in_ready`=1.
  - A following full frame produces correct windows despite stale buffer contents.
- **Back-to-back frames**: a new `sof` on the first cycle `in_ready` returns to 1.
  - Two complete frames, 24 windows, two `frame_done` pulses.

Source files
------------

// File: rtl/window_3x3_builder.sv
// -----------------------------------------------------------------------------
// window_3x3_builder
//
// Turns a raster-order RGB444 pixel stream into one 3x3 neighbourhood per image
// pixel, packed the way the 3x3 filter modules expect it on color_data.
// Two line buffers hold the previous two image lines; a 3x3 register window
// slides one column per accepted pixel. Neighbours that fall outside the image
// are zeroed. After the last pixel of a frame the block injects IMG_W+1 zero
// pixels on its own so that the bottom row of windows is produced.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high
//   pixel_in      RGB444 pixel, R[11:8] G[7:4] B[3:0]
//   pixel_valid   pixel_in valid this cycle
//   sof           start of frame, qualified by pixel_valid (raster index 0)
//   in_ready      block accepts a pixel this cycle (low only while flushing)
//   color_data    window: [107:96] C, [95:84] L, [83:72] R, [71:60] U,
//                 [59:48] D, [47:36] UL, [35:24] UR, [23:12] DL, [11:0] DR
//   window_valid  one-cycle strobe per window
//   center_x/y    coordinates of the window centre
//   frame_done    pulse together with the last window of a frame
// -----------------------------------------------------------------------------
module window_3x3_builder #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [11:0]                pixel_in,
  input  logic                       pixel_valid,
  input  logic                       sof,
  output logic                       in_ready,
  output logic [107:0]               color_data,
  output logic                       window_valid,
  output logic [$clog2(IMG_W)-1:0]   center_x,
  output logic [$clog2(IMG_H)-1:0]   center_y,
  output logic                       frame_done
);

  localparam int XW  = $clog2(IMG_W);
  // input row counter runs past the image by two rows during the flush
  localparam int YW  = $clog2(IMG_H + 2);
  localparam int CYW = $clog2(IMG_H);

  localparam logic [XW-1:0]  X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(IMG_H - 1);
  localparam logic [CYW-1:0] CY_LAST = CYW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [XW-1:0]           in_x_q, in_x_d;
  logic [YW-1:0]           in_y_q, in_y_d;
  logic [XW-1:0]           cx_q, cx_d;
  logic [CYW-1:0]          cy_q, cy_d;
  // win_q[row][col]: row 0 = up, 1 = centre row, 2 = down; col 2 is newest
  logic [2:0][2:0][11:0]   win_q, win_d;
  logic [107:0]            color_q, color_d;
  logic                    wvalid_q, wvalid_d;
  logic                    fdone_q, fdone_d;
  logic [XW-1:0]           center_x_q, center_x_d;
  logic [CYW-1:0]          center_y_q, center_y_d;

  // lb0 holds the line above the incoming pixel, lb1 the line above that
  logic [11:0]             lb0_q [0:IMG_W-1];
  logic [11:0]             lb1_q [0:IMG_W-1];

  logic                    flushing_s;
  logic                    restart_s;
  logic                    step_s;
  logic [XW-1:0]           ex_s;
  logic [YW-1:0]           ey_s;
  logic [11:0]             pix_s;
  logic [11:0]             top_new_s;
  logic [11:0]             mid_new_s;
  logic                    emit_s;
  logic                    last_s;
  logic                    m_left_s, m_right_s, m_up_s, m_down_s;
  logic [107:0]            window_s;

  assign flushing_s = (state_q == S_FLUSH);
  // sof restarts the frame from IDLE or STREAM; it is not seen while flushing
  assign restart_s  = pixel_valid & sof & ~flushing_s;
  // one raster position is consumed: a real pixel or an injected flush zero
  assign step_s     = flushing_s | (pixel_valid & (sof | (state_q == S_STREAM)));
  // position of the pixel consumed this cycle (index 0 on a restart)
  assign ex_s       = restart_s ? XW'(0) : in_x_q;
  assign ey_s       = restart_s ? YW'(0) : in_y_q;
  assign pix_s      = flushing_s ? 12'h000 : pixel_in;
  assign top_new_s  = lb1_q[ex_s];
  assign mid_new_s  = lb0_q[ex_s];

  // a window is complete once the consumed index reaches IMG_W+1
  assign emit_s = step_s & (flushing_s | (ey_s >= YW'(2)) |
                            ((ey_s == YW'(1)) & (ex_s != XW'(0))));
  assign last_s = emit_s & (cx_q == X_LAST) & (cy_q == CY_LAST);

  // masks also hide stale line-buffer data and the previous line on row wrap
  assign m_left_s  = (cx_q == XW'(0));
  assign m_right_s = (cx_q == X_LAST);
  assign m_up_s    = (cy_q == CYW'(0));
  assign m_down_s  = (cy_q == CY_LAST);

  // window as it will look after this cycle's shift, with out-of-image zeroing
  assign window_s = {
    win_q[1][2],
    m_left_s                ? 12'h000 : win_q[1][1],
    m_right_s               ? 12'h000 : mid_new_s,
    m_up_s                  ? 12'h000 : win_q[0][2],
    m_down_s                ? 12'h000 : win_q[2][2],
    (m_up_s   | m_left_s)   ? 12'h000 : win_q[0][1],
    (m_up_s   | m_right_s)  ? 12'h000 : top_new_s,
    (m_down_s | m_left_s)   ? 12'h000 : win_q[2][1],
    (m_down_s | m_right_s)  ? 12'h000 : pix_s
  };

  assign in_ready     = ~flushing_s;
  assign color_data   = color_q;
  assign window_valid = wvalid_q;
  assign frame_done   = fdone_q;
  assign center_x     = center_x_q;
  assign center_y     = center_y_q;

  // Next-state logic: window shift, counters, output capture and FSM
  always_comb begin
    state_d    = state_q;
    in_x_d     = in_x_q;
    in_y_d     = in_y_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    win_d      = win_q;
    color_d    = color_q;
    wvalid_d   = 1'b0;
    fdone_d    = 1'b0;
    center_x_d = center_x_q;
    center_y_d = center_y_q;

    if (step_s) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = top_new_s;
      win_d[1][2] = mid_new_s;
      win_d[2][2] = pix_s;
      if (ex_s == X_LAST) begin
        in_x_d = XW'(0);
        in_y_d = ey_s + YW'(1);
      end else begin
        in_x_d = ex_s + XW'(1);
        in_y_d = ey_s;
      end
    end else begin
      win_d = win_q;
    end

    if (restart_s) begin
      cx_d = XW'(0);
      cy_d = CYW'(0);
    end else if (emit_s) begin
      if (cx_q == X_LAST) begin
        cx_d = XW'(0);
        if (cy_q == CY_LAST) begin
          cy_d = CYW'(0);
        end else begin
          cy_d = cy_q + CYW'(1);
        end
      end else begin
        cx_d = cx_q + XW'(1);
      end
    end else begin
      cx_d = cx_q;
    end

    if (emit_s) begin
      color_d    = window_s;
      wvalid_d   = 1'b1;
      fdone_d    = last_s;
      center_x_d = cx_q;
      center_y_d = cy_q;
    end else begin
      wvalid_d = 1'b0;
    end

    // the final window ends the flush; counters start over for the next frame
    if (last_s) begin
      in_x_d = XW'(0);
      in_y_d = YW'(0);
    end else begin
      fdone_d = fdone_d;
    end

    case (state_q)
      S_IDLE: begin
        if (restart_s) begin
          state_d = S_STREAM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (step_s && !restart_s && (ex_s == X_LAST) && (ey_s == Y_LAST)) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_FLUSH: begin
        if (last_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FLUSH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      in_x_q     <= '0;
      in_y_q     <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      win_q      <= '0;
      color_q    <= '0;
      wvalid_q   <= 1'b0;
      fdone_q    <= 1'b0;
      center_x_q <= '0;
      center_y_q <= '0;
    end else begin
      state_q    <= state_d;
      in_x_q     <= in_x_d;
      in_y_q     <= in_y_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      win_q      <= win_d;
      color_q    <= color_d;
      wvalid_q   <= wvalid_d;
      fdone_q    <= fdone_d;
      center_x_q <= center_x_d;
      center_y_q <= center_y_d;
    end
  end

  // Line buffers: age the column by one line and store the consumed pixel
  always_ff @(posedge clk) begin
    if (step_s) begin
      lb1_q[ex_s] <= lb0_q[ex_s];
      lb0_q[ex_s] <= pix_s;
    end
  end

endmodule

// File: tb/tb_window_3x3_builder.sv
module tb_window_3x3_builder;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic                     clk;
  logic                     reset;
  logic [11:0]              pixel_in;
  logic                     pixel_valid;
  logic                     sof;
  logic                     in_ready;
  logic [107:0]             color_data;
  logic                     window_valid;
  logic [$clog2(W)-1:0]     center_x;
  logic [$clog2(H)-1:0]     center_y;
  logic                     frame_done;

  window_3x3_builder #(.IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .sof          (sof),
    .in_ready     (in_ready),
    .color_data   (color_data),
    .window_valid (window_valid),
    .center_x     (center_x),
    .center_y     (center_y),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state: the frame as an image plus raster bookkeeping
  logic [11:0]  img [N];
  int           n_m = 0;
  bit           streaming = 0;
  int           flush_left = 0;
  bit           m_started = 0;
  logic [107:0] last_win = '0;
  int           last_cx = 0;
  int           last_cy = 0;

  // observations
  logic [107:0] obs_win [N];
  logic [107:0] basic_win [N];
  int           strobes = 0;
  int           fd_cnt = 0;
  int           nrdy = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] px(input int x, input int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return 12'h000;
    return img[y*W + x];
  endfunction

  function automatic logic [107:0] win(input int c);
    int x, y;
    x = c % W;
    y = c / W;
    return {px(x, y), px(x-1, y), px(x+1, y), px(x, y-1), px(x, y+1),
            px(x-1, y-1), px(x+1, y-1), px(x-1, y+1), px(x+1, y+1)};
  endfunction

  task automatic clear_obs();
    strobes = 0;
    fd_cnt  = 0;
    nrdy    = 0;
  endtask

  // one clock cycle: drive, predict, clock, compare
  task automatic step(input logic v, input logic s, input logic [11:0] p);
    logic         exp_rdy, exp_v, exp_fd;
    logic [107:0] exp_w;
    int           c;
    pixel_valid = v;
    sof         = s;
    pixel_in    = p;
    exp_rdy     = (flush_left == 0);
    exp_v       = 1'b0;
    exp_fd      = 1'b0;
    exp_w       = last_win;
    c           = 0;
    m_started   = 0;
    #1;
    chk("in_ready", in_ready, exp_rdy);
    if (!in_ready) nrdy++;
    if (flush_left > 0) begin
      c = N - flush_left;
      exp_v = 1'b1;
      flush_left--;
    end else if (v) begin
      if (s) begin
        img[0]    = p;
        n_m       = 1;
        streaming = 1;
        m_started = 1;
      end else if (streaming) begin
        img[n_m] = p;
        if (n_m >= W + 1) begin
          c = n_m - W - 1;
          exp_v = 1'b1;
        end
        if (n_m == N - 1) begin
          streaming  = 0;
          flush_left = W + 1;
        end
        n_m++;
      end
    end
    if (exp_v) begin
      exp_w  = win(c);
      exp_fd = (c == N - 1);
    end
    @(posedge clk);
    #1;
    chk("window_valid", window_valid, exp_v);
    chk("frame_done", frame_done, exp_fd);
    if (exp_v) begin
      chk("color_data", color_data, exp_w);
      chk("center_x", center_x, c % W);
      chk("center_y", center_y, c / W);
      last_win = exp_w;
      last_cx  = c % W;
      last_cy  = c / W;
    end else begin
      chk("hold_color", color_data, last_win);
      chk("hold_cx", center_x, last_cx);
      chk("hold_cy", center_y, last_cy);
    end
    if (window_valid) begin
      strobes++;
      if (center_x < W && center_y < H) obs_win[center_y*W + center_x] = color_data;
    end
    if (frame_done) fd_cnt++;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    pixel_valid = 1'b0;
    sof         = 1'b0;
    pixel_in    = 12'h000;
    @(posedge clk);
    #1;
    chk("rst_color", color_data, 108'h0);
    chk("rst_wvalid", window_valid, 1'b0);
    chk("rst_fdone", frame_done, 1'b0);
    chk("rst_cx", center_x, 0);
    chk("rst_cy", center_y, 0);
    chk("rst_ready", in_ready, 1'b1);
    reset      = 1'b0;
    flush_left = 0;
    streaming  = 0;
    n_m        = 0;
    last_win   = '0;
    last_cx    = 0;
    last_cy    = 0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < N; i++) step(1'b1, i == 0, 12'($urandom));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 12'h000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [107:0] w_first, w_mid, w_last;
    int           i, guard, tries;
    logic         v;

    reset       = 1'b1;
    pixel_valid = 1'b0;
    sof         = 1'b0;
    pixel_in    = 12'h000;
    do_reset();

    // basic frame: values index+1, sof ignored while flushing
    clear_obs();
    for (int k = 0; k < N; k++) step(1'b1, k == 0, 12'(k + 1));
    for (int k = 0; k < W + 1; k++) step(1'b1, 1'b1, 12'($urandom));
    idle(3);
    w_first = {12'h001, 12'h000, 12'h002, 12'h000, 12'h005,
               12'h000, 12'h000, 12'h000, 12'h006};
    w_mid   = {12'h006, 12'h005, 12'h007, 12'h002, 12'h00A,
               12'h001, 12'h003, 12'h009, 12'h00B};
    w_last  = {12'h00C, 12'h00B, 12'h000, 12'h008, 12'h000,
               12'h007, 12'h000, 12'h000, 12'h000};
    chk("basic_first", obs_win[0], w_first);
    chk("basic_c11", obs_win[W + 1], w_mid);
    chk("basic_last", obs_win[N - 1], w_last);
    chk("basic_strobes", strobes, N);
    chk("basic_fdone", fd_cnt, 1);
    chk("flush_notready", nrdy, W + 1);
    for (int k = 0; k < N; k++) basic_win[k] = obs_win[k];

    // stalls: same frame, valid low about half the time
    clear_obs();
    i = 0;
    guard = 0;
    while (i < N && guard < 1000) begin
      v = 1'($urandom_range(0, 1));
      step(v, v && (i == 0), 12'(i + 1));
      if (v) i++;
      guard++;
    end
    chk("stall_sent", i, N);
    idle(W + 3);
    chk("stall_strobes", strobes, N);
    chk("stall_fdone", fd_cnt, 1);
    for (int k = 0; k < N; k++) chk("stall_win", obs_win[k], basic_win[k]);

    // pixels before sof are dropped, then a sof at index 7 aborts the frame
    clear_obs();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 12'($urandom));
    chk("presof_strobes", strobes, 0);
    for (int k = 0; k < 7; k++) step(1'b1, k == 0, 12'($urandom));
    chk("abort_fdone", fd_cnt, 0);
    send_frame();
    idle(W + 2);
    chk("abort_strobes", strobes, 2 + N);
    chk("abort_fdone_total", fd_cnt, 1);

    // reset mid-frame, then a full frame over stale buffers
    for (int k = 0; k < 9; k++) step(1'b1, k == 0, 12'($urandom));
    do_reset();
    clear_obs();
    send_frame();
    idle(W + 2);
    chk("post_rst_strobes", strobes, N);

    // reset mid-flush
    send_frame();
    idle(2);
    do_reset();
    idle(2);

    // back-to-back frames: sof retried until accepted
    clear_obs();
    send_frame();
    tries = 0;
    m_started = 0;
    while (!m_started && tries < 20) begin
      step(1'b1, 1'b1, 12'($urandom));
      tries++;
    end
    chk("b2b_tries", tries, W + 2);
    for (int k = 1; k < N; k++) step(1'b1, 1'b0, 12'($urandom));
    idle(W + 2);
    chk("b2b_strobes", strobes, 2 * N);
    chk("b2b_fdone", fd_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
